reaction_game_ctrl: RTL
=======================

// Module: reaction_game_ctrl
// PURPOSE
//  Reaction-time game controller; sits directly upstream of the MAX7219 matrix driver and supplies its digit/display_active inputs.
//  Debounces one push-button, waits a pseudo-random delay, shows a "GO" symbol and measures the reaction time.
//  Shows the result as tenths of a second (0-9), or a sad smiley on a false start.
//  Runs on the 1 MHz system clock; all timing derives from an internal tick prescaler.
// PARAMETERS
//  TICK_DIV        10000  clk cycles per tick (10 ms at 1 MHz); >= 2
//  DEBOUNCE_TICKS  3      consecutive equal tick samples required to accept a new button level; >= 1
//  MIN_WAIT_TICKS  100    fixed part of the ARM delay, in ticks; the random part adds 0..255
//  SHOW_TICKS      300    ticks that RESULT/FALSE_START are held before returning to IDLE
// PORTS
//  clk             in   1  system clock, 1 MHz
//  rst_n           in   1  asynchronous, active-low reset
//  btn_raw         in   1  raw push-button, active-high, asynchronous to clk
//  digit           out  4  symbol code for the driver: 0-9 digits, 10 happy, 11 neutral, 12 sad
//  display_active  out  1  1 = matrix lit, 0 = blank
//  score           out  4  last reaction score 0-9; holds its value until the next result
//  score_valid     out  1  one-clk pulse when score is updated
// BEHAVIOUR
//  Reset: state=IDLE, digit=11, display_active=1, score=0, score_valid=0, LFSR=8'hA5; all counters cleared.
//  Synchroniser: btn_raw passes through a 2-FF synchroniser, then the debouncer.
//  Tick: a counter runs 0..TICK_DIV-1 and tick=1 for one clk when count==TICK_DIV-1. The counter is free-running and is never reset by the FSM.
//  Debounce:
//   - The synchronised level is sampled only on tick.
//   - The debounced level changes after DEBOUNCE_TICKS consecutive samples differ from it.
//   - press = one-clk pulse on each 0->1 transition of the debounced level.
//  LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Advances every clk and is never 0.
//  All outputs are registered and change on the clk edge after the FSM transition (1-clk latency).
//  FSM:
//   - IDLE: digit=11, display_active=1. On press -> ARM, with wait_cnt <= MIN_WAIT_TICKS + lfsr (9-bit add, no overflow).
//   - ARM: display_active=0.
//       - On press -> FALSE_START.
//       - Otherwise wait_cnt decrements on each tick; on a tick with wait_cnt==1 -> GO.
//       - If a press and the expiry occur in the same clk, press wins (FALSE_START).
//   - GO: digit=10, display_active=1.
//       - Entry clears sub_cnt (0..9) and tenths (0..9).
//       - Each tick: sub_cnt increments; on wrap 9->0, tenths increments and saturates at 9.
//       - On press -> RESULT with score <= tenths. A tick in the same clk is not counted.
//       - If tenths==9 and sub_cnt wraps -> RESULT with score <= 9 (timeout).
//   - RESULT: digit=score, display_active=1.
//       - score_valid pulses in the first clk of RESULT.
//       - hold_cnt counts ticks; at SHOW_TICKS -> IDLE.
//       - A press -> IDLE immediately.
//   - FALSE_START: digit=12, display_active=1. Goes to IDLE after SHOW_TICKS ticks; presses are ignored.
//  Button-held case: a press is an edge only; a button held across a state change produces no new press.
//  A reset mid-game (any state) returns to IDLE with the reset values above; no score_valid is generated.
//  Unused state encodings -> IDLE.
// STRUCTURE
//  Shared include game_defs.vh:
//   - symbol codes SYM_HAPPY=4'd10, SYM_NEUTRAL=4'd11, SYM_SAD=4'd12
//   - state encodings IDLE/ARM/GO/RESULT/FALSE_START (3-bit)
//  Sub-module btn_debounce (synchroniser + tick-sampled debouncer + press pulse), with ports clk, rst_n, tick, btn_raw, press.
//  Tick prescaler, LFSR and FSM live in the top level.
// TESTING  (bench uses TICK_DIV=4, DEBOUNCE_TICKS=2, MIN_WAIT_TICKS=3, SHOW_TICKS=5)
//  1. Reset -> digit=11, display_active=1, score=0, score_valid=0. Assert and release rst_n mid-GO -> back to IDLE, no score_valid.
//  2. Glitch on btn_raw: high for 1 tick only -> no press, state stays IDLE. High for >=3 ticks -> ARM, display_active=0.
//  3. Normal round: press in IDLE, wait until digit=10, release, then press again 25 ticks after GO -> score=2, score_valid one clk, digit=2. After 5 ticks -> IDLE.
//  4. False start: press during ARM -> digit=12, display_active=1 for 5 ticks -> IDLE. Also force press and wait expiry in the same clk -> FALSE_START.
//  5. Timeout: no press in GO for 100 ticks -> RESULT, score=9. A press in RESULT -> IDLE next clk.
//  6. ARM delay: check ticks from ARM entry to GO == MIN_WAIT_TICKS + LFSR value at press; LFSR never 0 over 300 clk.

Source files
------------

// File: rtl/reaction_game_ctrl_pkg.sv
// Reaction-time game shared definitions:
// display symbol codes, FSM states and the LFSR step.
package reaction_game_ctrl_pkg;

    localparam logic [3:0] SYM_HAPPY   = 4'd10;
    localparam logic [3:0] SYM_NEUTRAL = 4'd11;
    localparam logic [3:0] SYM_SAD     = 4'd12;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_GO     = 3'd2,
        ST_RESULT = 3'd3,
        ST_FALSE  = 3'd4
    } state_t;

    // Fibonacci x^8+x^6+x^5+x^4+1, shifting towards the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/reaction_game_ctrl_btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, tick-sampled
// debouncer and a rising-edge press pulse aligned to the tick.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip  = tick && (sync[1] != level) && (cnt == CW'(DEBOUNCE_TICKS - 1));
    assign press = flip && sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], btn_raw};
            if (tick) begin
                if (flip) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else if (sync[1] != level) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller feeding the MAX7219 matrix driver:
// tick prescaler, LFSR delay source and the game FSM.
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
#(
    parameter int TICK_DIV       = 10000,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int MIN_WAIT_TICKS = 100,
    parameter int SHOW_TICKS     = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_raw,
    output logic [3:0] digit,
    output logic       display_active,
    output logic [3:0] score,
    output logic       score_valid
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int WW = $clog2(MIN_WAIT_TICKS + 256);
    localparam int HW = $clog2(SHOW_TICKS + 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          press;
    logic [7:0]    lfsr;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [3:0]    sub_cnt;
    logic [3:0]    tenths;
    logic [3:0]    res;
    logic          res_new;
    logic [HW-1:0] hold_cnt;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr_next(lfsr);
    end

    btn_debounce #(
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .btn_raw(btn_raw),
        .press  (press)
    );

    // Outputs are decoded from the current state, so they trail it by one clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            sub_cnt        <= '0;
            tenths         <= '0;
            res            <= '0;
            res_new        <= 1'b0;
            hold_cnt       <= '0;
            digit          <= SYM_NEUTRAL;
            display_active <= 1'b1;
            score          <= '0;
            score_valid    <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    digit          <= SYM_NEUTRAL;
                    display_active <= 1'b1;
                    if (press) begin
                        state    <= ST_ARM;
                        wait_cnt <= WW'(MIN_WAIT_TICKS) + WW'(lfsr);
                    end
                end
                ST_ARM: begin
                    digit          <= SYM_NEUTRAL;
                    display_active <= 1'b0;
                    if (press) begin
                        state    <= ST_FALSE;
                        hold_cnt <= '0;
                    end else if (tick) begin
                        if (wait_cnt == WW'(1)) begin
                            state   <= ST_GO;
                            sub_cnt <= '0;
                            tenths  <= '0;
                        end else begin
                            wait_cnt <= wait_cnt - WW'(1);
                        end
                    end
                end
                ST_GO: begin
                    digit          <= SYM_HAPPY;
                    display_active <= 1'b1;
                    if (press) begin
                        state    <= ST_RESULT;
                        res      <= tenths;
                        res_new  <= 1'b1;
                        hold_cnt <= '0;
                    end else if (tick) begin
                        if (sub_cnt == 4'd9) begin
                            sub_cnt <= '0;
                            if (tenths == 4'd9) begin
                                state    <= ST_RESULT;
                                res      <= 4'd9;
                                res_new  <= 1'b1;
                                hold_cnt <= '0;
                            end else begin
                                tenths <= tenths + 4'd1;
                            end
                        end else begin
                            sub_cnt <= sub_cnt + 4'd1;
                        end
                    end
                end
                ST_RESULT: begin
                    digit          <= res;
                    display_active <= 1'b1;
                    res_new        <= 1'b0;
                    if (res_new) begin
                        score       <= res;
                        score_valid <= 1'b1;
                    end
                    if (press) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        if (hold_cnt == HW'(SHOW_TICKS - 1)) state <= ST_IDLE;
                        else hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_FALSE: begin
                    digit          <= SYM_SAD;
                    display_active <= 1'b1;
                    if (tick) begin
                        if (hold_cnt == HW'(SHOW_TICKS - 1)) state <= ST_IDLE;
                        else hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    digit          <= SYM_NEUTRAL;
                    display_active <= 1'b1;
                end
            endcase
        end
    end

endmodule
